// File: rtl/imem_sync.sv
// Synchronous writable instruction memory: NOP fill after reset, valid/ready fetch port, byte-enabled loader port.
// Optional macro IMEM_WR_BYPASS_EN: a fetch colliding with a same-cycle loader write returns the merged new word.
module imem_sync #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter logic [31:0] NOP_WORD   = 32'h00000013
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_instr,
  output logic                  rsp_fault,
  input  logic                  prog_we,
  input  logic [3:0]            prog_be,
  input  logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [31:0]           prog_data,
  output logic                  init_busy
);

  localparam int unsigned WORD_AW = ADDR_WIDTH - 2;
  localparam int unsigned DEPTH   = 2 ** WORD_AW;
  localparam logic [WORD_AW-1:0] LAST_IDX = WORD_AW'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e               state_r;
  state_e               state_nxt_s;
  logic [WORD_AW-1:0]   fill_cnt_r;
  logic [WORD_AW-1:0]   fill_cnt_nxt_s;
  logic                 init_busy_r;
  logic                 init_busy_nxt_s;
  logic                 fill_wr_s;

  logic [31:0]          mem_r [DEPTH];

  logic                 req_ready_s;
  logic                 accept_s;
  logic                 prog_wr_s;
  logic [WORD_AW-1:0]   req_idx_s;
  logic [WORD_AW-1:0]   prog_idx_s;
  logic                 req_fault_s;
  logic [31:0]          merged_s;
  logic [31:0]          rd_word_s;

  logic                 rsp_valid_r;
  logic [31:0]          rsp_instr_r;
  logic                 rsp_fault_r;

  // Loader byte lanes are word-granular; the low address bits carry no information.
  logic                 unused_addr_s;
  assign unused_addr_s = ^prog_addr[1:0];

  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (new_word & mask) | (old_word & ~mask);
  endfunction

  // Fill-FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_INIT;
      fill_cnt_r  <= '0;
      init_busy_r <= 1'b1;
    end else begin
      state_r     <= state_nxt_s;
      fill_cnt_r  <= fill_cnt_nxt_s;
      init_busy_r <= init_busy_nxt_s;
    end
  end

  // Fill-FSM next state: one NOP word per cycle, READY after the last index
  always_comb begin
    state_nxt_s     = state_r;
    fill_cnt_nxt_s  = fill_cnt_r;
    init_busy_nxt_s = init_busy_r;
    fill_wr_s       = 1'b0;
    case (state_r)
      ST_INIT: begin
        fill_wr_s      = rst_n;
        fill_cnt_nxt_s = fill_cnt_r + WORD_AW'(1);
        if (fill_cnt_r == LAST_IDX) begin
          state_nxt_s     = ST_READY;
          init_busy_nxt_s = 1'b0;
        end else begin
          state_nxt_s     = ST_INIT;
          init_busy_nxt_s = 1'b1;
        end
      end
      ST_READY: begin
        state_nxt_s     = ST_READY;
        init_busy_nxt_s = 1'b0;
      end
      default: begin
        state_nxt_s     = ST_INIT;
        fill_cnt_nxt_s  = '0;
        init_busy_nxt_s = 1'b1;
      end
    endcase
  end

  assign req_idx_s   = req_addr[ADDR_WIDTH-1:2];
  assign prog_idx_s  = prog_addr[ADDR_WIDTH-1:2];
  assign req_fault_s = (req_addr[1:0] != 2'b00);
  assign req_ready_s = (state_r == ST_READY) && (!rsp_valid_r || rsp_ready);
  assign accept_s    = req_valid && req_ready_s;
  assign prog_wr_s   = rst_n && prog_we && (state_r == ST_READY);
  assign merged_s    = byte_merge(mem_r[prog_idx_s], prog_data, prog_be);

  // Storage array; writes during the fill are dropped because fill_wr_s has priority
  always_ff @(posedge clk) begin
    if (fill_wr_s) begin
      mem_r[fill_cnt_r] <= NOP_WORD;
    end else if (prog_wr_s) begin
      mem_r[prog_idx_s] <= merged_s;
    end
  end

  // Read data source for an accepted fetch
  always_comb begin
    rd_word_s = mem_r[req_idx_s];
`ifdef IMEM_WR_BYPASS_EN
    if (prog_wr_s && (prog_idx_s == req_idx_s)) begin
      rd_word_s = merged_s;
    end else begin
      rd_word_s = mem_r[req_idx_s];
    end
`endif
  end

  // Response hold register: load on accept, drop valid on retire, otherwise hold
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_r <= 1'b0;
      rsp_instr_r <= NOP_WORD;
      rsp_fault_r <= 1'b0;
    end else if (accept_s) begin
      rsp_valid_r <= 1'b1;
      rsp_instr_r <= req_fault_s ? NOP_WORD : rd_word_s;
      rsp_fault_r <= req_fault_s;
    end else if (rsp_ready) begin
      rsp_valid_r <= 1'b0;
    end
  end

  assign req_ready = req_ready_s;
  assign rsp_valid = rsp_valid_r;
  assign rsp_instr = rsp_instr_r;
  assign rsp_fault = rsp_fault_r;
  assign init_busy = init_busy_r;

endmodule

// File: tb/tb_imem_sync.sv
// Self-checking bench for imem_sync (ADDR_WIDTH=6): directed plan steps plus random traffic against a behavioural model.
module tb_imem_sync;

  localparam int          AW    = 6;
  localparam int          DEPTH = 16;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_instr;
  logic          rsp_fault;
  logic          prog_we;
  logic [3:0]    prog_be;
  logic [AW-1:0] prog_addr;
  logic [31:0]   prog_data;
  logic          init_busy;

  int n_cmp  = 0;
  int n_fail = 0;

  // behavioural model of the block as seen from its ports
  logic [31:0] m_mem [DEPTH];
  bit          m_known = 1'b0;
  bit          m_ready;
  bit          m_valid;
  bit          m_fault;
  bit          m_busy;
  logic [31:0] m_instr;
  int          m_fill;

  always #5 clk = ~clk;

  imem_sync #(.ADDR_WIDTH(AW), .NOP_WORD(NOP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_instr (rsp_instr),
    .rsp_fault (rsp_fault),
    .prog_we   (prog_we),
    .prog_be   (prog_be),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .init_busy (init_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

  // Drive one cycle of inputs, check outputs against the model, then advance the model across the edge.
  task automatic cycle(input logic rst, input logic rv, input logic [AW-1:0] ra, input logic rr,
                       input logic we, input logic [3:0] be, input logic [AW-1:0] pa,
                       input logic [31:0] pd);
    logic [31:0] w;
    int          idx;
    rst_n = rst; req_valid = rv; req_addr = ra; rsp_ready = rr;
    prog_we = we; prog_be = be; prog_addr = pa; prog_data = pd;
    #1;
    if (m_known) begin
      chk("req_ready", 32'(req_ready), 32'(m_ready && (!m_valid || rr)));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
      chk("rsp_instr", rsp_instr, m_instr);
      chk("rsp_fault", 32'(rsp_fault), 32'(m_fault));
      chk("init_busy", 32'(init_busy), 32'(m_busy));
    end
    @(posedge clk);
    if (!rst) begin
      m_known = 1'b1; m_ready = 1'b0; m_fill = 0; m_busy = 1'b1;
      m_valid = 1'b0; m_instr = NOP; m_fault = 1'b0;
    end else if (!m_ready) begin
      m_mem[m_fill] = NOP;
      m_fill++;
      if (m_fill == DEPTH) begin
        m_ready = 1'b1;
        m_busy  = 1'b0;
      end
    end else begin
      if (rv && (!m_valid || rr)) begin
        idx = int'(ra) / 4;
        if ((int'(ra) % 4) != 0) begin
          m_instr = NOP;
          m_fault = 1'b1;
        end else begin
          w = m_mem[idx];
`ifdef IMEM_WR_BYPASS_EN
          if (we && (int'(pa) / 4 == idx)) w = model_merge(w, pd, be);
`endif
          m_instr = w;
          m_fault = 1'b0;
        end
        m_valid = 1'b1;
      end else if (rr) begin
        m_valid = 1'b0;
      end
      if (we) m_mem[int'(pa) / 4] = model_merge(m_mem[int'(pa) / 4], pd, be);
    end
    #1;
  endtask

  task automatic idle(input logic rr);
    cycle(1'b1, 1'b0, '0, rr, 1'b0, 4'h0, '0, 32'h0);
  endtask

  task automatic fetch(input logic [AW-1:0] a, input logic rr);
    cycle(1'b1, 1'b1, a, rr, 1'b0, 4'h0, '0, 32'h0);
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [3:0] be, input logic [31:0] d);
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b1, be, a, d);
  endtask

  logic [31:0] coll_exp;

  initial begin
    // reset and NOP fill
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, 4'h0, '0, 32'h0);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, 4'h0, '0, 32'h0);
    for (int i = 0; i < DEPTH; i++) begin
      chk("fill_busy", 32'(init_busy), 32'd1);
      chk("fill_no_ready", 32'(req_ready), 32'd0);
      load(6'h00, 4'hF, 32'hDEADBEEF);
    end
    chk("fill_done_busy", 32'(init_busy), 32'd0);
    chk("fill_done_ready", 32'(req_ready), 32'd1);
    fetch(6'h00, 1'b1);
    chk("nop_0x00", rsp_instr, NOP);
    chk("nop_0x00_fault", 32'(rsp_fault), 32'd0);
    fetch(6'h3C, 1'b1);
    chk("nop_0x3c", rsp_instr, NOP);
    idle(1'b1);

    // program load and back-to-back fetch
    load(6'h00, 4'hF, 32'hFEDCB0B7);
    load(6'h04, 4'hF, 32'h78900113);
    load(6'h08, 4'hF, 32'h001100B3);
    fetch(6'h00, 1'b1);
    chk("b2b_0_valid", 32'(rsp_valid), 32'd1);
    chk("b2b_0", rsp_instr, 32'hFEDCB0B7);
    fetch(6'h04, 1'b1);
    chk("b2b_1_valid", 32'(rsp_valid), 32'd1);
    chk("b2b_1", rsp_instr, 32'h78900113);
    fetch(6'h08, 1'b1);
    chk("b2b_2_valid", 32'(rsp_valid), 32'd1);
    chk("b2b_2", rsp_instr, 32'h001100B3);
    idle(1'b1);

    // byte enable
    load(6'h10, 4'b0010, 32'hAABBCCDD);
    fetch(6'h10, 1'b1);
    chk("byte_en", rsp_instr, 32'h0000CC13);
    idle(1'b1);

    // backpressure with a write to the held word
    fetch(6'h04, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, 6'h08, 1'b0, 1'b1, 4'hF, 6'h04, 32'h11111111);
      chk("bp_hold", rsp_instr, 32'h78900113);
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_no_ready", 32'(req_ready), 32'd0);
    end
    idle(1'b1);
    chk("bp_retire", 32'(rsp_valid), 32'd0);
    fetch(6'h04, 1'b1);
    chk("bp_new_word", rsp_instr, 32'h11111111);

    // misaligned fetch
    fetch(6'h06, 1'b1);
    chk("fault_flag", 32'(rsp_fault), 32'd1);
    chk("fault_instr", rsp_instr, NOP);
    fetch(6'h08, 1'b1);
    chk("after_fault_flag", 32'(rsp_fault), 32'd0);
    chk("after_fault_instr", rsp_instr, 32'h001100B3);

    // same-cycle fetch and write collision
`ifdef IMEM_WR_BYPASS_EN
    coll_exp = 32'h22222222;
`else
    coll_exp = NOP;
`endif
    cycle(1'b1, 1'b1, 6'h0C, 1'b1, 1'b1, 4'hF, 6'h0C, 32'h22222222);
    chk("collision", rsp_instr, coll_exp);
    fetch(6'h0C, 1'b1);
    chk("collision_after", rsp_instr, 32'h22222222);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(1'b1, 1'($urandom_range(0, 1)), AW'($urandom), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 2) == 0), 4'($urandom), AW'($urandom), $urandom);
    end

    // reset with a pending response
    fetch(6'h00, 1'b0);
    chk("pre_reset_valid", 32'(rsp_valid), 32'd1);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 4'h0, '0, 32'h0);
    chk("reset_drops_valid", 32'(rsp_valid), 32'd0);
    chk("reset_busy", 32'(init_busy), 32'd1);
    for (int i = 0; i < DEPTH; i++) idle(1'b1);
    fetch(6'h00, 1'b1);
    chk("refill_0x00", rsp_instr, NOP);
    idle(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_sync.md
Name: imem_sync

Overview:
- Synchronous, writable instruction memory; parametrised successor to the combinational fixed-program ROM.
- Sits between the fetch stage and a program loader.
- Fetch side uses a valid/ready request/response handshake with one-cycle latency and an output hold register.
- After reset, an init FSM fills every word with NOP. The loader then writes the program through a byte-enabled port.

Parameters:
- ADDR_WIDTH, 10, byte-address width; DEPTH = 2**(ADDR_WIDTH-2) words.
- NOP_WORD, 32'h00000013, fill value after reset and the instruction returned on a fault.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  block can accept a fetch this cycle.
- req_addr  in  ADDR_WIDTH  fetch byte address.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts the response.
- rsp_instr  out  32  fetched instruction.
- rsp_fault  out  1  fetch address misaligned.
- prog_we  in  1  loader write strobe.
- prog_be  in  4  byte enables; bit i writes bits [8i+7:8i].
- prog_addr  in  ADDR_WIDTH  loader byte address; bits [1:0] ignored.
- prog_data  in  32  loader write data.
- init_busy  out  1  NOP fill in progress.

Behaviour:
- Reset (rst_n=0 sampled at posedge):
  - state=INIT, fill counter=0.
  - rsp_valid=0, rsp_instr=NOP_WORD, rsp_fault=0, init_busy=1, req_ready=0.
  - Array contents are not reset directly; the fill rewrites them.
- INIT state:
  - Each cycle writes NOP_WORD to word[counter], then increments counter.
  - When counter==DEPTH-1 is written, next state is READY and init_busy=0 in the following cycle. The fill takes exactly DEPTH cycles.
  - During INIT: req_ready=0, and prog_we is ignored (dropped, not queued).
- READY state:
  - Terminal until the next reset. A reset mid-fill or mid-fetch restarts the fill from word 0 and discards any pending response.
- req_ready = (state==READY) && (!rsp_valid || rsp_ready). This is combinational.
- Request accept: req_valid && req_ready at a posedge. At the next posedge:
  - rsp_valid=1.
  - rsp_instr = word[req_addr[ADDR_WIDTH-1:2]].
  - rsp_fault = (req_addr[1:0]!=0). On a fault, rsp_instr=NOP_WORD instead.
- Backpressure:
  - While rsp_valid && !rsp_ready, rsp_instr and rsp_fault hold stable and no new request is accepted.
  - A later loader write to the same word does not alter the held response.
- Response retire: rsp_valid && rsp_ready with no new accept gives rsp_valid=0 next cycle. rsp_instr keeps its last value.
- Back-to-back: when the response retires and a new request is accepted in the same cycle, rsp_valid stays 1 with new data. Throughput is one fetch per cycle.
- Loader write: prog_we in READY updates enabled bytes of word[prog_addr[ADDR_WIDTH-1:2]] at the posedge. Writes are always accepted; there is no ready signal.
- Same-cycle accept and write to the same word: the result depends on the macro (see Optional Feature).
- Address wrap: no out-of-range case exists, since DEPTH covers the full address space.

Optional Feature:
- Macro: IMEM_WR_BYPASS_EN.
- Defined: a fetch accepted in the same cycle as a prog_we to the same word returns the merged new word (old bytes where prog_be=0, new bytes elsewhere).
- Undefined: the same fetch returns the old word (read-first). The write still lands and is visible to any later fetch.
- A misaligned fetch returns NOP_WORD with fault in both builds.

Test Plan:
- Reset with ADDR_WIDTH=6:
  - init_busy=1 for 16 cycles, req_ready=0 throughout; then init_busy=0 and req_ready=1.
  - Fetches of 0x00, 0x3C -> rsp_instr=0x00000013, rsp_fault=0.
- Load and fetch:
  - Load 0x00=FEDCB0B7, 0x04=78900113, 0x08=001100B3 with be=4'hF.
  - Back-to-back fetches 0x00, 0x04, 0x08 with rsp_ready=1 -> responses on 3 consecutive cycles in order, rsp_valid continuous.
- Byte enables: word 0x10 = 0x00000013; write be=4'b0010, data 0xAABBCCDD -> fetch returns 0x0000CC13.
- Backpressure:
  - Fetch 0x04, hold rsp_ready=0 for 5 cycles while writing 0x11111111 to 0x04 -> rsp_instr stays 78900113 and req_ready=0 throughout.
  - Release rsp_ready -> rsp_valid drops next cycle; a new fetch of 0x04 returns 0x11111111.
- Fault: fetch 0x06 -> rsp_fault=1, rsp_instr=0x00000013. The next fetch, 0x08, returns fault=0.
- Collision and reset:
  - Same-cycle fetch and write of 0x22222222 to 0x0C -> rsp_instr=0x22222222 with IMEM_WR_BYPASS_EN, old word without.
  - Assert rst_n=0 with rsp_valid=1 -> rsp_valid=0 next cycle, fill restarts, and previously loaded 0x00 reads 0x00000013 after init.
